// File: rtl/reg_access_pkg.sv
// Shared encodings for the register access controller: command opcodes and FSM states.
package reg_access_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WRITE   = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_e;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Command, response and register-file signals of the register access controller.
interface reg_access_ctrl_if
    import reg_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    op_e               cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    logic [ADDR_W-1:0] rf_rs1;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wd;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rd1;

    logic              busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, rf_rd1,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err,
        output rf_rs1, rf_rd, rf_wd, rf_we, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, rf_rd1,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err,
        input  rf_rs1, rf_rd, rf_wd, rf_we, busy
    );

endinterface

// File: rtl/reg_access_ctrl.sv
// Sequences single reads/writes and full-file dumps against an external register file,
// returning one response per register touched.
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_access_ctrl_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;

    logic              cmd_ready_q;
    logic              busy_q;
    logic              rsp_valid_q;
    logic              rsp_last_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] rf_rs1_q;
    logic [ADDR_W-1:0] rf_rd_q;
    logic [DATA_W-1:0] rf_wd_q;
    logic              rf_we_q;

    // NOTE: all state and outputs update with <= in one clocked block; reset is sampled on
    // the clock edge only, so an aborted command leaves no pulse or response behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rf_rs1_q    <= '0;
            rf_rd_q     <= '0;
            rf_wd_q     <= '0;
            rf_we_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_q        <= bus.cmd_op;
                        wdata_q     <= bus.cmd_wdata;
                        addr_q      <= (bus.cmd_op == OP_DUMP) ? '0 : bus.cmd_addr;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        unique case (bus.cmd_op)
                            OP_READ, OP_DUMP: begin
                                state_q  <= CAPTURE;
                                rf_rs1_q <= (bus.cmd_op == OP_DUMP) ? '0 : bus.cmd_addr;
                            end
                            OP_WRITE: begin
                                state_q <= WRITE;
                                rf_rd_q <= bus.cmd_addr;
                                rf_wd_q <= bus.cmd_wdata;
                                // x0 is hardwired to zero: the write is acknowledged but never issued
                                rf_we_q <= (bus.cmd_addr != '0);
                            end
                            default: begin
                                state_q     <= RESP;
                                data_q      <= '0;
                                rsp_valid_q <= 1'b1;
                                rsp_last_q  <= 1'b1;
                                rsp_err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    data_q      <= wdata_q;
                    rf_rd_q     <= '0;
                    rf_wd_q     <= '0;
                    rf_we_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_last_q  <= 1'b1;
                end
                CAPTURE: begin
                    state_q     <= RESP;
                    data_q      <= bus.rf_rd1;
                    rf_rs1_q    <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_last_q  <= (op_q != OP_DUMP) || (addr_q == LAST_IDX);
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_last_q  <= 1'b0;
                        if (op_q == OP_DUMP && addr_q != LAST_IDX) begin
                            state_q  <= CAPTURE;
                            addr_q   <= addr_q + 1'b1;
                            rf_rs1_q <= addr_q + 1'b1;
                        end else begin
                            // Ready rises only after this edge, so no accept can share the handshake cycle
                            state_q     <= IDLE;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = addr_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rf_rs1    = rf_rs1_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.rf_we     = rf_we_q;

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, the register data width.
REQ-002 Parameter ADDR_W, default 5, the register index width; the register count is 2**ADDR_W.
REQ-003 Port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, reset; the block SHALL use one clock and a synchronous, active-low reset.
REQ-005 Port cmd_valid, input, 1 bit, command present.
REQ-006 Port cmd_ready, output, 1 bit, the block accepts a command.
REQ-007 Port cmd_op, input, 2 bits, the command: 00 read, 01 write, 10 dump, 11 reserved.
REQ-008 Port cmd_addr, input, ADDR_W bits, the target register index.
REQ-009 Port cmd_wdata, input, DATA_W bits, the write data.
REQ-010 Port rsp_valid, output, 1 bit, response present.
REQ-011 Port rsp_ready, input, 1 bit, the consumer accepts the response.
REQ-012 Port rsp_addr, output, ADDR_W bits, the register index the response refers to.
REQ-013 Port rsp_data, output, DATA_W bits, the read data (reads and dumps) or the written data (writes).
REQ-014 Port rsp_last, output, 1 bit, marks the final response of a command.
REQ-015 Port rsp_err, output, 1 bit, reserved opcode.
REQ-016 Port rf_rs1, output, ADDR_W bits, the register file read index.
REQ-017 Port rf_rd, output, ADDR_W bits, the register file write index.
REQ-018 Port rf_wd, output, DATA_W bits, the register file write data.
REQ-019 Port rf_we, output, 1 bit, the register file write enable.
REQ-020 Port rf_rd1, input, DATA_W bits, the register file combinational read data for rf_rs1.
REQ-021 Port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-022 The FSM states SHALL be IDLE, WRITE, CAPTURE and RESP.
REQ-023 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid and cmd_ready both 1, and its op, addr and wdata are latched into op_q, addr_q and wdata_q.
REQ-024 On accepting a read or a dump, the FSM SHALL go from IDLE to CAPTURE.
REQ-025 On accepting a write, the FSM SHALL go from IDLE to WRITE.
REQ-026 On accepting a reserved op, the FSM SHALL go from IDLE to RESP with rsp_err=1, rsp_data=0 and rsp_last=1.
REQ-027 In CAPTURE, rf_rs1 SHALL equal addr_q; rf_rd1 is registered into data_q at the end of the cycle, then the FSM goes to RESP.
REQ-028 In WRITE, for exactly one cycle: rf_rd=addr_q, rf_wd=wdata_q, and rf_we=1 unless addr_q==0.
REQ-029 A write to x0 SHALL NOT assert rf_we but SHALL still respond normally; after WRITE, data_q=wdata_q and the FSM goes to RESP.
REQ-030 Outside WRITE, rf_we SHALL be 0 and rf_rd and rf_wd SHALL be 0.
REQ-031 Outside CAPTURE, rf_rs1 SHALL be 0.
REQ-032 In RESP, rsp_valid SHALL be 1 and rsp_addr, rsp_data, rsp_last and rsp_err SHALL be held stable until rsp_ready=1.
REQ-033 A response handshake SHALL occur on a rising edge with rsp_valid and rsp_ready both 1.
REQ-034 For reads, writes and reserved ops, rsp_last SHALL be 1 and the FSM returns to IDLE after the handshake.
REQ-035 A dump SHALL start at index 0 regardless of cmd_addr.
REQ-036 During a dump, after each handshake with addr_q<31 the FSM SHALL increment addr_q and return to CAPTURE; at addr_q==31, rsp_last=1 and the FSM returns to IDLE; addr_q SHALL never wrap.
REQ-037 Latency SHALL be: read accepted at edge N gives rsp_valid from edge N+2; write accepted at edge N gives rf_we high in cycle N+1 and rsp_valid from edge N+2.
REQ-038 A dump with rsp_ready held at 1 SHALL produce 32 responses in 64 cycles.
REQ-039 rsp_valid SHALL be 0 in every state except RESP.
REQ-040 A new command SHALL NOT be accepted in the same cycle as a response handshake.

Reset
REQ-041 While rst_n=0 at a rising edge: state becomes IDLE; op_q, addr_q, wdata_q and data_q become 0.
REQ-042 Reset SHALL drive all outputs to 0 except cmd_ready=1.
REQ-043 A reset arriving mid-command or mid-dump SHALL abort it without any further rf_we pulse or response.

Structure
REQ-044 Opcode encodings and the state enumeration SHALL live in the shared package reg_access_pkg.
REQ-045 The block SHALL be a single module with no sub-module; the register file stays external.

Verification
REQ-046 Write x1=67, then x3=69: rf_we pulses one cycle each with rf_rd=1/rf_wd=67 and rf_rd=3/rf_wd=69; the responses carry rsp_data 67 and 69.
REQ-047 Read x1 then x3: rf_rs1=1 in the CAPTURE cycle; rsp_data=67 at edge N+2; next rsp_data=69; rsp_last=1 on each.
REQ-048 Write x0=5, then read x0: rf_we stays 0 for the write; the write response has data 5; the read returns 0.
REQ-049 Dump with rsp_ready=1: 32 responses with rsp_addr 0..31 in order, rsp_last only on 31, 64 cycles total.
REQ-050 Dump with rsp_ready toggled 1-0, and rst_n=0 for one cycle after response 10: outputs stay stable while stalled; after reset the state is IDLE, rsp_valid=0 and no further responses occur.
REQ-051 cmd_op=11: exactly one response with rsp_err=1 and rsp_last=1, and rf_we stays 0.
